multicycle_control_unit: RTL and testbench

Multi-cycle sequencer for the MIPS-subset CPU. It replaces single-cycle decode with a state machine that steps each instruction through the IF/ID/EXE/MEM/WB phases. It drives the instruction-memory read, the IR and PC write enables, the register-file, ALU and data-memory controls, and the next-PC mux. It sits between the IR fields (op, func) and ALU flags on one side and every datapath enable on the other.

---
 rtl/cpu_defs_pkg.sv | 65 ++++++
 rtl/control_decode.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU control path.
// Holds the sequencer state encoding, opcode/func constants, ALUOp codes,
// PCSrc/RegDst select codes and the instruction-class enum used by the decoder.
package cpu_defs_pkg;

    typedef enum logic [3:0] {
        sIF     = 4'd0,
        sID     = 4'd1,
        sEXE_AL = 4'd2,
        sWB_AL  = 4'd3,
        sEXE_BR = 4'd4,
        sEXE_LS = 4'd5,
        sMEM    = 4'd6,
        sWB_LD  = 4'd7,
        sHALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, HALT, NOP
    } ins_class_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Function codes (op = OP_RTYPE)
    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_JR  = 6'b001000;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    // ALUOp codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Next-PC select
    localparam logic [1:0] PCSRC_NEXT   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Destination register select
    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder.
// Inputs : op, func - IR opcode and function fields.
// Outputs: ins_class - instruction class driving the sequencer,
//          alu_op    - ALU function for the execute phase,
//          ext_sel   - immediate extension (1 = sign, 0 = zero).
module control_decode
    import cpu_defs_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    output ins_class_t  ins_class,
    output logic [2:0]  alu_op,
    output logic        ext_sel
);

    always_comb begin
        ins_class = NOP;
        alu_op    = ALU_ADD;
        ext_sel   = 1'b0;
        case (op)
            OP_RTYPE: begin
                ins_class = ALU_R;
                case (func)
                    FUNC_ADD: alu_op = ALU_ADD;
                    FUNC_SUB: alu_op = ALU_SUB;
                    FUNC_AND: alu_op = ALU_AND;
                    FUNC_OR:  alu_op = ALU_OR;
                    FUNC_SLT: alu_op = ALU_SLT;
                    FUNC_SLL: alu_op = ALU_SLL;
                    FUNC_JR:  ins_class = JUMP;
                    default:  ins_class = NOP;
                endcase
            end
            OP_ADDIU: begin ins_class = ALU_I;  alu_op = ALU_ADD; ext_sel = 1'b1; end
            OP_SLTI:  begin ins_class = ALU_I;  alu_op = ALU_SLT; ext_sel = 1'b1; end
            OP_ANDI:  begin ins_class = ALU_I;  alu_op = ALU_AND; end
            OP_ORI:   begin ins_class = ALU_I;  alu_op = ALU_OR;  end
            OP_LW:    begin ins_class = LOAD;   alu_op = ALU_ADD; ext_sel = 1'b1; end
            OP_SW:    begin ins_class = STORE;  alu_op = ALU_ADD; ext_sel = 1'b1; end
            // bltz compares rs against rt=$0, so every branch subtracts
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                ins_class = BRANCH;
                alu_op    = ALU_SUB;
                ext_sel   = 1'b1;
            end
            OP_J, OP_JAL: ins_class = JUMP;
            OP_HALT:      ins_class = HALT;
            default:      ins_class = NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: steps each instruction through IF/ID/EXE/MEM/WB and
// drives every datapath enable combinationally from the current state and IR.
// Inputs : CLK, Reset (async, active-low), op/func (IR fields), Zero/Sign (ALU flags).
// Outputs: InsMemRW, IRWre, PCWre, PCSrc, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
//          RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR.
module multicycle_control_unit
    import cpu_defs_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       Sign,
    output logic       InsMemRW,
    output logic       IRWre,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR
);

    state_t     state_q, state_d;
    ins_class_t ins_class;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       branch_taken;

    control_decode u_decode (
        .op        (op),
        .func      (func),
        .ins_class (ins_class),
        .alu_op    (alu_op),
        .ext_sel   (ext_sel)
    );

    assign branch_taken = ((op == OP_BEQ)  &&  Zero) ||
                          ((op == OP_BNE)  && !Zero) ||
                          ((op == OP_BLTZ) &&  Sign);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= sIF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = sIF;
        unique case (state_q)
            sIF: state_d = sID;
            sID: begin
                case (ins_class)
                    ALU_R, ALU_I:  state_d = sEXE_AL;
                    BRANCH:        state_d = sEXE_BR;
                    LOAD, STORE:   state_d = sEXE_LS;
                    HALT:          state_d = sHALT;
                    default:       state_d = sIF;     // JUMP, NOP
                endcase
            end
            sEXE_AL: state_d = sWB_AL;
            sWB_AL:  state_d = sIF;
            sEXE_BR: state_d = sIF;
            sEXE_LS: state_d = sMEM;
            sMEM:    state_d = (ins_class == LOAD) ? sWB_LD : sIF;
            sWB_LD:  state_d = sIF;
            sHALT:   state_d = sHALT;
            default: state_d = sIF;
        endcase
    end

    always_comb begin
        InsMemRW  = 1'b0;
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = PCSRC_NEXT;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        RegDst    = REGDST_RA;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        unique case (state_q)
            sIF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
            end
            sID: begin
                if (ins_class == JUMP) begin
                    PCWre = 1'b1;
                    if (op == OP_RTYPE) begin
                        PCSrc = PCSRC_RS;
                    end else begin
                        PCSrc = PCSRC_JUMP;
                        if (op == OP_JAL) begin
                            RegWre    = 1'b1;
                            RegDst    = REGDST_RA;
                            WrRegDSrc = 1'b0;     // link value is PC+4
                        end
                    end
                end else if (ins_class == NOP) begin
                    PCWre = 1'b1;
                    PCSrc = PCSRC_NEXT;
                end
            end
            // Write-back repeats the execute controls so the ALU result stays valid
            sEXE_AL, sWB_AL: begin
                ALUOp   = alu_op;
                ALUSrcB = (ins_class == ALU_I);
                ALUSrcA = (ins_class == ALU_R) && (func == FUNC_SLL);
                ExtSel  = ext_sel;
                if (state_q == sWB_AL) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b0;
                    PCWre     = 1'b1;
                    RegDst    = (ins_class == ALU_R) ? REGDST_RD : REGDST_RT;
                end
            end
            sEXE_BR: begin
                ALUOp  = alu_op;
                ExtSel = ext_sel;
                PCWre  = 1'b1;
                PCSrc  = branch_taken ? PCSRC_BRANCH : PCSRC_NEXT;
            end
            sEXE_LS, sMEM: begin
                ALUOp   = alu_op;
                ALUSrcB = 1'b1;
                ExtSel  = ext_sel;
                if (state_q == sMEM) begin
                    if (ins_class == LOAD) begin
                        mRD = 1'b1;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
            end
            sWB_LD: begin
                RegWre    = 1'b1;
                RegDst    = REGDST_RT;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
            end
            default: ;  // sHALT and unused encodings: everything idle
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
// All control outputs are packed into one 18-bit vector and compared per cycle
// against hand-built expected vectors, sampled on the falling clock edge.
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       Zero = 1'b0;
    logic       Sign = 1'b0;
    logic       InsMemRW, IRWre, PCWre, ExtSel, ALUSrcA, ALUSrcB;
    logic       WrRegDSrc, DBDataSrc, RegWre, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;
    logic [17:0] ctrl;

    int tests = 0;
    int fails = 0;

    multicycle_control_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .op        (op),
        .func      (func),
        .Zero      (Zero),
        .Sign      (Sign),
        .InsMemRW  (InsMemRW),
        .IRWre     (IRWre),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .ExtSel    (ExtSel),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .DBDataSrc (DBDataSrc),
        .RegWre    (RegWre),
        .mRD       (mRD),
        .mWR       (mWR)
    );

    always #5 CLK = ~CLK;

    assign ctrl = {InsMemRW, IRWre, PCWre, PCSrc, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                   RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR};

    // Packs fields in the same order as ctrl
    function automatic logic [17:0] v(input logic im, input logic ir, input logic pw,
                                      input logic [1:0] ps, input logic ex, input logic sa,
                                      input logic sb, input logic [2:0] ao,
                                      input logic [1:0] rd, input logic wd, input logic db,
                                      input logic rw, input logic mr, input logic mw);
        return {im, ir, pw, ps, ex, sa, sb, ao, rd, wd, db, rw, mr, mw};
    endfunction

    logic [17:0] v_if, v_zero;

    // Leaves the bench at a falling edge with the DUT in sIF
    task automatic test_reset();
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", ctrl, v_if);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL reset_held: got %h expected %h", ctrl, v_if);
        end
        @(negedge CLK);
        Reset = 1'b1;
        tests++;
        if (IRWre !== 1'b1 || ctrl !== v_if) begin
            fails++;
            $display("FAIL reset_release_if: got %h expected %h", ctrl, v_if);
        end
    endtask

    task automatic test_alu();
        logic [5:0]  ops [4];
        logic [5:0]  fns [4];
        logic [17:0] exe [4];
        logic [17:0] wb  [4];
        logic [17:0] exp [4];
        ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001010};
        fns = '{6'b100000, 6'b000000, 6'b000000, 6'b000000};
        // add, sll, ori, slti
        exe[0] = v_zero;
        wb[0]  = v(0, 0, 1, 2'b00, 0, 0, 0, 3'b000, 2'b10, 1, 0, 1, 0, 0);
        exe[1] = v(0, 0, 0, 2'b00, 0, 1, 0, 3'b010, 2'b00, 0, 0, 0, 0, 0);
        wb[1]  = v(0, 0, 1, 2'b00, 0, 1, 0, 3'b010, 2'b10, 1, 0, 1, 0, 0);
        exe[2] = v(0, 0, 0, 2'b00, 0, 0, 1, 3'b011, 2'b00, 0, 0, 0, 0, 0);
        wb[2]  = v(0, 0, 1, 2'b00, 0, 0, 1, 3'b011, 2'b01, 1, 0, 1, 0, 0);
        exe[3] = v(0, 0, 0, 2'b00, 1, 0, 1, 3'b101, 2'b00, 0, 0, 0, 0, 0);
        wb[3]  = v(0, 0, 1, 2'b00, 1, 0, 1, 3'b101, 2'b01, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            op   = ops[i];
            func = fns[i];
            exp  = '{v_if, v_zero, exe[i], wb[i]};
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ctrl !== exp[c]) begin
                    fails++;
                    $display("FAIL alu[%0d] cycle %0d: got %h expected %h",
                             i, c + 1, ctrl, exp[c]);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_lw();
        logic [17:0] exp [5];
        op   = 6'b100011;
        func = 6'b000000;
        exp[0] = v_if;
        exp[1] = v_zero;
        exp[2] = v(0, 0, 0, 2'b00, 1, 0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        exp[3] = v(0, 0, 0, 2'b00, 1, 0, 1, 3'b000, 2'b00, 0, 0, 0, 1, 0);
        exp[4] = v(0, 0, 1, 2'b00, 0, 0, 0, 3'b000, 2'b01, 1, 1, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (ctrl !== exp[c]) begin
                fails++;
                $display("FAIL lw cycle %0d: got %h expected %h", c + 1, ctrl, exp[c]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_sw();
        logic [17:0] exp [4];
        op   = 6'b101011;
        func = 6'b000000;
        exp[0] = v_if;
        exp[1] = v_zero;
        exp[2] = v(0, 0, 0, 2'b00, 1, 0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        exp[3] = v(0, 0, 1, 2'b00, 1, 0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 1);
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (ctrl !== exp[c]) begin
                fails++;
                $display("FAIL sw cycle %0d: got %h expected %h", c + 1, ctrl, exp[c]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [7];
        logic        zs  [7];
        logic        ss  [7];
        logic [1:0]  ps  [7];
        logic [17:0] exp [3];
        ops = '{6'b000100, 6'b000100, 6'b000101, 6'b000101, 6'b000001, 6'b000001, 6'b000100};
        zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ss  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ps  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            op   = ops[i];
            func = 6'b000000;
            Zero = zs[i];
            Sign = ss[i];
            exp  = '{v_if, v_zero, v(0, 0, 1, ps[i], 1, 0, 0, 3'b001, 2'b00, 0, 0, 0, 0, 0)};
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (ctrl !== exp[c]) begin
                    fails++;
                    $display("FAIL branch[%0d] cycle %0d: got %h expected %h",
                             i, c + 1, ctrl, exp[c]);
                end
                @(negedge CLK);
            end
        end
        Zero = 1'b0;
        Sign = 1'b0;
    endtask

    // PCSrc must follow Zero combinationally while in the branch execute state
    task automatic test_flag_live();
        op   = 6'b000100;
        func = 6'b000000;
        Zero = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (PCSrc !== 2'b00) begin
            fails++;
            $display("FAIL flag_live_zero0: got %b expected 00", PCSrc);
        end
        Zero = 1'b1;
        #1;
        tests++;
        if (PCSrc !== 2'b01) begin
            fails++;
            $display("FAIL flag_live_zero1: got %b expected 01", PCSrc);
        end
        Zero = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_jump();
        logic [5:0]  ops [5];
        logic [5:0]  fns [5];
        logic [17:0] idv [5];
        logic [17:0] exp [2];
        // j, jal, jr, unknown opcode, unknown func
        ops = '{6'b000010, 6'b000011, 6'b000000, 6'b111000, 6'b000000};
        fns = '{6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b111111};
        idv[0] = v(0, 0, 1, 2'b11, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idv[1] = v(0, 0, 1, 2'b11, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0);
        idv[2] = v(0, 0, 1, 2'b10, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idv[3] = v(0, 0, 1, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idv[4] = idv[3];
        for (int i = 0; i < 5; i++) begin
            op   = ops[i];
            func = fns[i];
            exp  = '{v_if, idv[i]};
            for (int c = 0; c < 2; c++) begin
                tests++;
                if (ctrl !== exp[c]) begin
                    fails++;
                    $display("FAIL jump[%0d] cycle %0d: got %h expected %h",
                             i, c + 1, ctrl, exp[c]);
                end
                @(negedge CLK);
            end
        end
    endtask

    // Reset in the write cycle must drop RegWre / mWR in the same timestep
    task automatic test_async_reset();
        op   = 6'b000000;
        func = 6'b100000;
        repeat (3) @(negedge CLK);
        tests++;
        if (RegWre !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre_regwre: got %b expected 1", RegWre);
        end
        #1 Reset = 1'b0;
        #1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL midreset_regwre: got %h expected %h", ctrl, v_if);
        end
        @(negedge CLK);
        Reset = 1'b1;
        op = 6'b101011;
        repeat (3) @(negedge CLK);
        tests++;
        if (mWR !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre_mwr: got %b expected 1", mWR);
        end
        #1 Reset = 1'b0;
        #1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL midreset_mwr: got %h expected %h", ctrl, v_if);
        end
        @(negedge CLK);
        Reset = 1'b1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL midreset_release: got %h expected %h", ctrl, v_if);
        end
    endtask

    task automatic test_halt();
        logic [17:0] jal_id;
        op   = 6'b111111;
        func = 6'b000000;
        @(negedge CLK);
        for (int c = 0; c < 21; c++) begin
            tests++;
            if (ctrl !== v_zero) begin
                fails++;
                $display("FAIL halt cycle %0d: got %h expected %h", c + 2, ctrl, v_zero);
            end
            @(negedge CLK);
        end
        #1 Reset = 1'b0;
        #1;
        tests++;
        if (ctrl !== v_if) begin
            fails++;
            $display("FAIL halt_reset: got %h expected %h", ctrl, v_if);
        end
        @(negedge CLK);
        Reset = 1'b1;
        op = 6'b000011;
        jal_id = v(0, 0, 1, 2'b11, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0);
        @(negedge CLK);
        tests++;
        if (ctrl !== jal_id) begin
            fails++;
            $display("FAIL halt_resume_jal: got %h expected %h", ctrl, jal_id);
        end
        @(negedge CLK);
    endtask

    initial begin
        v_if   = v(1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        v_zero = '0;
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_branch();
        test_flag_live();
        test_jump();
        test_async_reset();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
